// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS boot path.
// Holds the program-loader state encoding and stream framing constants.
package mips_pkg;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LEN_BYTES  = 2;

endpackage

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into 32-bit words.
// word reflects the register with the byte being accepted merged in at the low end.
module word_assembler
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        shift,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [31:0] word_q;
    logic [1:0]  byte_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
        end else if (clear) begin
            byte_cnt_q <= '0;
        end else if (shift) begin
            word_q     <= {word_q[23:0], byte_in};
            byte_cnt_q <= byte_cnt_q + 2'd1;
        end
    end

    // Asserted on the accept that completes the word, so the caller can latch it same-edge.
    always_comb begin
        word      = {word_q[23:0], byte_in};
        word_full = shift && (byte_cnt_q == 2'(WORD_BYTES - 1));
    end

endmodule

// File: rtl/inst_loader.sv
// Boot-time program loader: length-prefixed byte stream in, instruction-memory writes out.
// Holds the processor in reset until the whole program has been written.
module inst_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        start,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] IDX_ONE = 1;

    loader_state_t         state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic        accept;
    logic        asm_shift;
    logic        asm_clear;
    logic        word_full;
    logic [31:0] asm_word;
    logic [15:0] len_full;
    logic        last_word;

    assign accept    = byte_valid & byte_ready;
    assign asm_shift = accept & (state_q == DATA);
    assign len_full  = {count_q[15:8], byte_data};
    assign last_word = (32'(word_idx_q) == (32'(count_q) - 32'd1));

    word_assembler u_word_assembler (
        .clock     (clock),
        .reset     (reset),
        .shift     (asm_shift),
        .clear     (asm_clear),
        .byte_in   (byte_data),
        .word      (asm_word),
        .word_full (word_full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= LEN_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LEN_HI: if (accept) state_d = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0) begin
                        state_d = DONE;
                    end else if (32'(len_full) > DEPTH) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA:      if (word_full) state_d = WRITE;
            WRITE:     state_d = last_word ? DONE : DATA;
            DONE, ERR: if (start) state_d = LEN_HI;
            default:   state_d = LEN_HI;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_hold   = 1'b1;
        unique case (state_q)
            LEN_HI, LEN_LO, DATA: byte_ready = 1'b1;
            WRITE:                mem_we     = 1'b1;
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    // Address/data are latched on the completing byte and then held, so they stay
    // stable through WRITE and afterwards until the next word completes.
    always_comb begin
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        asm_clear   = 1'b0;
        case (state_q)
            LEN_HI: if (accept) count_d[15:8] = byte_data;
            LEN_LO: begin
                if (accept) begin
                    count_d[7:0] = byte_data;
                    word_idx_d   = '0;
                    asm_clear    = 1'b1;
                end
            end
            WRITE: begin
                if (!last_word) begin
                    word_idx_d = word_idx_q + IDX_ONE;
                    asm_clear  = 1'b1;
                end
            end
            default: ;
        endcase
        if (word_full) begin
            mem_addr_d  = 32'(word_idx_q) << 2;
            mem_wdata_d = asm_word;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            word_idx_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
